// File: rtl/sm83_adr_pkg.sv
// Shared types for the SM83 address latch / burst address generator.
// Holds the half-split address view, the sequencer state encoding and a width helper.
package sm83_adr_pkg;

  localparam int ADR_WIDTH_DEFAULT = 16;

  function automatic int half_width(input int adr_width);
    return adr_width / 2;
  endfunction

  // Address seen as two halves; page-wrap mode only lets the low half move.
  typedef struct packed {
    logic [ADR_WIDTH_DEFAULT/2-1:0] hi;
    logic [ADR_WIDTH_DEFAULT/2-1:0] lo;
  } adr_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } burst_state_t;

endpackage

// File: rtl/sm83_adr_incdec.sv
// Combinational +/- carry-in unit for the address latch.
// 2-bit cells with group-carry lookahead per half; wrap cuts the low-to-high carry.
module sm83_adr_incdec
  import sm83_adr_pkg::*;
#(
  parameter int ADR_WIDTH = 16
) (
  input  logic [ADR_WIDTH-1:0] al,
  input  logic                 dec,
  input  logic                 cy,
  input  logic                 wrap,
  output logic [ADR_WIDTH-1:0] result
);

  localparam int HW = half_width(ADR_WIDTH);
  localparam int NG = (HW + 1) / 2;
  localparam int PW = 2 * NG;

  // A bit passes the carry on when it is 1 (increment) or 0 (decrement).
  logic [ADR_WIDTH-1:0] prop;
  logic                 lo_cout;
  logic                 hi_cin;

  assign prop    = dec ? ~al : al;
  assign lo_cout = cy & (&prop[HW-1:0]);
  assign hi_cin  = lo_cout & ~wrap;

  function automatic logic [HW-1:0] step_half(input logic [HW-1:0] a,
                                              input logic [HW-1:0] p,
                                              input logic          cin);
    logic [PW-1:0] pa;
    logic [PW-1:0] pp;
    logic [PW-1:0] r;
    logic [NG-1:0] gp;
    logic [NG-1:0] below;
    logic          gc;
    pa    = PW'(a);
    pp    = ~PW'(~p);  // pad cells propagate so an odd half needs no special case
    r     = pa;
    below = '0;
    for (int g = 0; g < NG; g++) gp[g] = pp[2*g] & pp[2*g+1];
    for (int g = 0; g < NG; g++) begin
      gc         = cin & (&(gp | ~below));
      r[2*g]     = pa[2*g] ^ gc;
      r[2*g+1]   = pa[2*g+1] ^ (gc & pp[2*g]);
      below[g]   = 1'b1;
    end
    return r[HW-1:0];
  endfunction

  assign result = {step_half(al[ADR_WIDTH-1:HW], prop[ADR_WIDTH-1:HW], hi_cin),
                   step_half(al[HW-1:0], prop[HW-1:0], cy)};

endmodule

// File: rtl/sm83_adr_burst.sv
// CPU address latch with inc/dec path, page-wrap mode and a valid/ready burst sequencer.
// All state advances on the falling clock edge.
module sm83_adr_burst
  import sm83_adr_pkg::*;
#(
  parameter int ADR_WIDTH = 16,
  parameter int LEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADR_WIDTH-1:0] ain,
  output logic [ADR_WIDTH-1:0] aout,
  output logic [ADR_WIDTH-1:0] aout_inc,
  input  logic                 ctl_al_we,
  input  logic                 ctl_al_hi_ff,
  input  logic                 ctl_inc_dec,
  input  logic                 ctl_inc_cy,
  input  logic                 ctl_inc_oe,
  input  logic                 ctl_page_wrap,
  input  logic                 burst_start,
  input  logic [LEN_WIDTH-1:0] burst_len,
  input  logic                 burst_dec,
  input  logic                 burst_wrap,
  input  logic                 burst_abort,
  output logic                 burst_busy,
  output logic                 burst_valid,
  input  logic                 burst_ready,
  output logic                 burst_last
);

  localparam int HW = half_width(ADR_WIDTH);

  typedef struct packed {
    logic [HW-1:0] hi;
    logic [HW-1:0] lo;
  } adr_split_t;

  burst_state_t         state;
  adr_split_t           al;
  adr_split_t           inc;
  logic [LEN_WIDTH-1:0] remaining;
  logic                 lat_dec;
  logic                 lat_wrap;
  logic                 eff_dec;
  logic                 eff_cy;
  logic                 eff_wrap;
  logic                 accept;

  // While bursting the sequencer owns the arithmetic controls.
  assign eff_dec  = (state == RUN) ? lat_dec  : ctl_inc_dec;
  assign eff_cy   = (state == RUN) ? 1'b1     : ctl_inc_cy;
  assign eff_wrap = (state == RUN) ? lat_wrap : ctl_page_wrap;

  sm83_adr_incdec #(
    .ADR_WIDTH(ADR_WIDTH)
  ) u_incdec (
    .al    (al),
    .dec   (eff_dec),
    .cy    (eff_cy),
    .wrap  (eff_wrap),
    .result(inc)
  );

  assign aout     = al;
  assign aout_inc = inc;
  assign accept   = burst_valid & burst_ready;

  // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
  always_ff @(negedge clk) begin
    // NOTE: every state bit is reset here; there is no storage array to leave unreset.
    if (reset) begin
      state       <= IDLE;
      al          <= '0;
      remaining   <= '0;
      lat_dec     <= 1'b0;
      lat_wrap    <= 1'b0;
      burst_busy  <= 1'b0;
      burst_valid <= 1'b0;
      burst_last  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (burst_start && (burst_len != '0)) begin
            state       <= RUN;
            al          <= ain;
            remaining   <= burst_len;
            lat_dec     <= burst_dec;
            lat_wrap    <= burst_wrap;
            burst_busy  <= 1'b1;
            burst_valid <= 1'b1;
            burst_last  <= (burst_len == LEN_WIDTH'(1));
          end else if (ctl_al_we) begin
            al.hi <= ctl_inc_oe ? inc.hi : (ctl_al_hi_ff ? '1 : ain[ADR_WIDTH-1:HW]);
            al.lo <= ctl_inc_oe ? inc.lo : ain[HW-1:0];
          end
        end
        RUN: begin
          if (accept) al <= inc;
          if (burst_abort || (accept && remaining == LEN_WIDTH'(1))) begin
            state       <= IDLE;
            remaining   <= '0;
            burst_busy  <= 1'b0;
            burst_valid <= 1'b0;
            burst_last  <= 1'b0;
          end else if (accept) begin
            remaining  <= remaining - LEN_WIDTH'(1);
            burst_last <= (remaining == LEN_WIDTH'(2));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm83_adr_burst.sv
// Self-checking bench for sm83_adr_burst: legacy latch path, arithmetic boundaries,
// burst sequencing with stall/wrap/decrement, abort and reset, against a queue scoreboard.
module tb_sm83_adr_burst;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ain;
  logic [15:0] aout;
  logic [15:0] aout_inc;
  logic        ctl_al_we, ctl_al_hi_ff, ctl_inc_dec, ctl_inc_cy, ctl_inc_oe, ctl_page_wrap;
  logic        burst_start;
  logic [7:0]  burst_len;
  logic        burst_dec, burst_wrap, burst_abort;
  logic        burst_busy, burst_valid, burst_ready, burst_last;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_q[$];

  sm83_adr_burst #(
    .ADR_WIDTH(16),
    .LEN_WIDTH(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ain          (ain),
    .aout         (aout),
    .aout_inc     (aout_inc),
    .ctl_al_we    (ctl_al_we),
    .ctl_al_hi_ff (ctl_al_hi_ff),
    .ctl_inc_dec  (ctl_inc_dec),
    .ctl_inc_cy   (ctl_inc_cy),
    .ctl_inc_oe   (ctl_inc_oe),
    .ctl_page_wrap(ctl_page_wrap),
    .burst_start  (burst_start),
    .burst_len    (burst_len),
    .burst_dec    (burst_dec),
    .burst_wrap   (burst_wrap),
    .burst_abort  (burst_abort),
    .burst_busy   (burst_busy),
    .burst_valid  (burst_valid),
    .burst_ready  (burst_ready),
    .burst_last   (burst_last)
  );

  always #5 clk = ~clk;

  // Reference step: plain arithmetic, with page wrap confining the change to the low byte.
  function automatic logic [15:0] model_step(input logic [15:0] a, input logic d, input logic w);
    logic [15:0] full;
    logic [7:0]  lo;
    full = d ? a - 16'd1 : a + 16'd1;
    lo   = d ? a[7:0] - 8'd1 : a[7:0] + 8'd1;
    return w ? {a[15:8], lo} : full;
  endfunction

  // Inputs change and outputs are sampled 1 time unit after the active falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; ain = '0;
    ctl_al_we = 1'b0; ctl_al_hi_ff = 1'b0; ctl_inc_dec = 1'b0;
    ctl_inc_cy = 1'b0; ctl_inc_oe = 1'b0; ctl_page_wrap = 1'b0;
    burst_start = 1'b0; burst_len = '0; burst_dec = 1'b0; burst_wrap = 1'b0;
    burst_abort = 1'b0; burst_ready = 1'b1;
  endtask

  task automatic load(input logic [15:0] a);
    ctl_al_we = 1'b1; ain = a;
    tick();
    ctl_al_we = 1'b0; ain = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    ctl_inc_cy = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    vectors++;
    if (aout !== 16'h0000) begin miscompares++; $display("FAIL reset_aout got %h exp 0000", aout); end
    vectors++;
    if ({burst_busy, burst_valid, burst_last} !== 3'b000) begin
      miscompares++; $display("FAIL reset_flags got %b exp 000", {burst_busy, burst_valid, burst_last});
    end
    vectors++;
    if (aout_inc !== 16'h0001) begin miscompares++; $display("FAIL reset_aout_inc got %h exp 0001", aout_inc); end
    ctl_inc_cy = 1'b0;
  endtask

  task automatic test_legacy();
    load(16'h12FF);
    vectors++;
    if (aout !== 16'h12FF) begin miscompares++; $display("FAIL legacy_load got %h exp 12FF", aout); end
    ctl_inc_oe = 1'b1; ctl_inc_cy = 1'b1;
    load(16'hAAAA);
    vectors++;
    if (aout !== 16'h1300) begin miscompares++; $display("FAIL legacy_inc got %h exp 1300", aout); end
    ctl_inc_dec = 1'b1;
    load(16'hAAAA);
    vectors++;
    if (aout !== 16'h12FF) begin miscompares++; $display("FAIL legacy_dec got %h exp 12FF", aout); end
    ctl_inc_oe = 1'b0; ctl_inc_dec = 1'b0; ctl_al_hi_ff = 1'b1;
    load(16'h3456);
    vectors++;
    if (aout !== 16'hFF56) begin miscompares++; $display("FAIL legacy_hi_ff got %h exp FF56", aout); end
    ctl_al_hi_ff = 1'b0;
    load(16'h1234);
    ctl_al_hi_ff = 1'b1; ctl_inc_oe = 1'b1;
    load(16'h5555);
    vectors++;
    if (aout !== 16'h1235) begin miscompares++; $display("FAIL legacy_oe_over_hi_ff got %h exp 1235", aout); end
    ctl_al_hi_ff = 1'b0; ctl_inc_oe = 1'b0; ctl_inc_cy = 1'b0;
  endtask

  task automatic test_boundaries();
    logic [15:0] al_v [5] = '{16'hFFFF, 16'h0000, 16'h80FF, 16'h8000, 16'h4321};
    logic        dec_v[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        wr_v [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        cy_v [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] exp_v[5] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h80FF, 16'h4321};
    for (int i = 0; i < 5; i++) begin
      load(al_v[i]);
      ctl_inc_dec = dec_v[i]; ctl_page_wrap = wr_v[i]; ctl_inc_cy = cy_v[i];
      #1;
      vectors++;
      if (aout_inc !== exp_v[i]) begin
        miscompares++; $display("FAIL boundary_%0d got %h exp %h", i, aout_inc, exp_v[i]);
      end
    end
    ctl_inc_dec = 1'b0; ctl_page_wrap = 1'b0; ctl_inc_cy = 1'b0;
  endtask

  task automatic run_burst(input logic [15:0] a0, input logic [7:0] len, input logic d,
                           input logic w, input int stall_beat, input int stall_n, input string tag);
    logic [15:0] a;
    int          beat;
    int          stalls;
    int          budget;
    exp_q.delete();
    a = a0;
    for (int i = 0; i < int'(len); i++) begin
      exp_q.push_back(a);
      a = model_step(a, d, w);
    end
    ain = a0; burst_len = len; burst_dec = d; burst_wrap = w; burst_start = 1'b1; burst_ready = 1'b1;
    tick();
    burst_start = 1'b0; ain = '0; burst_len = '0; burst_dec = 1'b0; burst_wrap = 1'b0;
    beat = 0; stalls = stall_n; budget = 100;
    while (exp_q.size() > 0 && budget > 0) begin
      budget--;
      vectors++;
      if (burst_valid !== 1'b1 || aout !== exp_q[0]) begin
        miscompares++;
        $display("FAIL %s_beat%0d got valid=%b aout=%h exp valid=1 aout=%h", tag, beat, burst_valid, aout, exp_q[0]);
      end
      if (beat == stall_beat && stalls > 0) begin
        burst_ready = 1'b0;
        stalls--;
        tick();
      end else begin
        vectors++;
        if (burst_last !== (exp_q.size() == 1)) begin
          miscompares++; $display("FAIL %s_last%0d got %b exp %b", tag, beat, burst_last, exp_q.size() == 1);
        end
        burst_ready = 1'b1;
        void'(exp_q.pop_front());
        beat++;
        tick();
      end
    end
    vectors++;
    if (budget == 0) begin miscompares++; $display("FAIL %s_timeout got budget=0 exp beats done", tag); end
    vectors++;
    if (burst_busy !== 1'b0 || aout !== a) begin
      miscompares++; $display("FAIL %s_end got busy=%b aout=%h exp busy=0 aout=%h", tag, burst_busy, aout, a);
    end
  endtask

  task automatic test_burst();
    run_burst(16'hFE9E, 8'd4, 1'b0, 1'b0, -1, 0, "burst_nostall");
    run_burst(16'hFEFE, 8'd3, 1'b0, 1'b1, 1, 2, "burst_stall_wrap");
    run_burst(16'h0001, 8'd3, 1'b1, 1'b0, -1, 0, "burst_dec");
    run_burst(16'hFFFF, 8'd1, 1'b0, 1'b0, 0, 1, "burst_single");
  endtask

  task automatic test_abort();
    ain = 16'h4000; burst_len = 8'd10; burst_start = 1'b1; burst_ready = 1'b1;
    tick();
    burst_start = 1'b0;
    tick();
    burst_ready = 1'b0; ctl_al_we = 1'b1; burst_start = 1'b1; ain = 16'hDEAD;
    tick();
    vectors++;
    if (aout !== 16'h4001 || burst_busy !== 1'b1) begin
      miscompares++; $display("FAIL abort_ignore got aout=%h busy=%b exp aout=4001 busy=1", aout, burst_busy);
    end
    ctl_al_we = 1'b0; burst_start = 1'b0; ain = '0; burst_abort = 1'b1;
    tick();
    vectors++;
    if (aout !== 16'h4001 || {burst_busy, burst_valid, burst_last} !== 3'b000) begin
      miscompares++; $display("FAIL abort_stalled got aout=%h flags=%b exp aout=4001 flags=000",
                              aout, {burst_busy, burst_valid, burst_last});
    end
    tick();
    vectors++;
    if (aout !== 16'h4001 || burst_busy !== 1'b0) begin
      miscompares++; $display("FAIL abort_idle got aout=%h busy=%b exp aout=4001 busy=0", aout, burst_busy);
    end
    burst_abort = 1'b0; burst_ready = 1'b1;
    ain = 16'h5000; burst_len = 8'd5; burst_start = 1'b1;
    tick();
    burst_start = 1'b0;
    tick();
    burst_abort = 1'b1;
    tick();
    burst_abort = 1'b0;
    vectors++;
    if (aout !== 16'h5002 || burst_busy !== 1'b0) begin
      miscompares++; $display("FAIL abort_accept got aout=%h busy=%b exp aout=5002 busy=0", aout, burst_busy);
    end
  endtask

  task automatic test_reset_mid_burst();
    ain = 16'h7000; burst_len = 8'd8; burst_start = 1'b1; burst_ready = 1'b1;
    tick();
    burst_start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (aout !== 16'h0000 || burst_busy !== 1'b0 || burst_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_mid got aout=%h busy=%b valid=%b exp 0000 0 0", aout, burst_busy, burst_valid);
    end
    ain = 16'h1111; burst_len = 8'd0; burst_start = 1'b1; ctl_al_we = 1'b1;
    tick();
    burst_start = 1'b0; ctl_al_we = 1'b0; ain = '0;
    vectors++;
    if (aout !== 16'h1111 || burst_busy !== 1'b0) begin
      miscompares++; $display("FAIL zero_len got aout=%h busy=%b exp aout=1111 busy=0", aout, burst_busy);
    end
  endtask

  initial begin
    test_reset();
    test_legacy();
    test_boundaries();
    test_burst();
    test_abort();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
